ram8_write_arbiter: RTL and testbench
=====================================

// Module: ram8_write_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single write port of an 8-word register bank among 8 requesters.
//   Drives the bank's 3-bit write select and load strobe, which the bank decodes through its 1-to-8 load demux.
//   Grants are bursts of up to MAX_BURST writes, with fair rotation between requesters.
//   Sits between the CPU/IO write sources and the RAM8 word array.
// PARAMETERS
//   WIDTH      16  data word width in bits
//   MAX_BURST  4   max accepted writes per grant before forced rotation (1..15)
// PORTS
//   clk       in   1          rising-edge clock, the only clock
//   rst_n     in   1          reset, asynchronous, active-low
//   req       in   8          req[i]: requester i has a write pending; held until accepted
//   addr      in   8*3        addr[3i+2:3i]: target word of requester i
//   data      in   8*WIDTH    data[WIDTH*i+WIDTH-1:WIDTH*i]: write data of requester i
//   gnt       out  8          one-hot or zero, registered; gnt[i]: requester i owns the port
//   wr_load   out  1          registered write strobe into the bank (load demux input)
//   wr_sel    out  3          registered word select (load demux select)
//   wr_data   out  WIDTH      registered write data
//   busy      out  1          1 while state is GRANT
// BEHAVIOUR
//   Reset (async, rst_n=0): gnt=0, wr_load=0, wr_sel=0, wr_data=0, busy=0, ptr=0, beat=0, state IDLE.
//     Reset mid-burst aborts the burst. A write already registered is dropped. The requester keeps req high and re-arbitrates.
//   Transfer: cycle with gnt[i]=1 and req[i]=1 accepts one write from requester i.
//     On the next edge: wr_load=1, wr_sel=addr_i, wr_data=data_i, each for exactly one cycle.
//     Any other cycle: wr_load=0 on the next edge. wr_sel and wr_data hold their last values.
//   Latency: req rises at edge t (from IDLE) -> gnt at t+1 -> wr_load at t+2. Sustained throughput is 1 write/cycle.
//   Arbitration: scan req starting at index ptr, upward mod 8; the first set bit wins.
//   FSM:
//     IDLE : gnt=0. If req!=0: gnt<=onehot(winner), beat<=0, go to GRANT. Else stay.
//     GRANT (owner o):
//       If req[o]=1 and beat+1<MAX_BURST: beat++, stay, gnt unchanged.
//       End of grant (req[o]=0, or accepted write with beat+1==MAX_BURST):
//         ptr<=(o+1) mod 8, re-arbitrate this cycle over req, with o at lowest priority.
//         Winner found: gnt<=winner, beat<=0, stay GRANT. Otherwise gnt<=0, go to IDLE.
//     req[o] falling while granted: no transfer that cycle; gnt moves or clears at the next edge.
//   Simultaneous requests: resolved by ptr only; no requester waits more than 7 grants.
//   Single requester: re-granted back-to-back; gnt stays high with no bubble, beat restarts at 0.
//   Wrap-around: ptr and scan roll 7 -> 0. beat never exceeds MAX_BURST-1.
//   addr/data are sampled only in accept cycles; changes at other times have no effect.
//   gnt is never multi-hot. busy = (state==GRANT).
// TESTING
//   1. Reset, req=8'h01, addr0=5, data0=16'hBEEF, drop req after first accept
//      -> gnt=01 at t+1; wr_load=1, wr_sel=5, wr_data=BEEF at t+2 for one cycle; then IDLE.
//   2. req=8'hFF held, MAX_BURST=4 -> gnt order 0,1,...,7,0, each held 4 cycles; wr_load continuous, no gaps.
//   3. ptr=6, req=8'h41 -> requester 6 granted first, then requester 0 (wrap); ptr ends at 1.
//   4. Only req[3] held for 10 cycles -> gnt[3] held throughout, 10 wr_load pulses, beat wraps 0..3.
//   5. req[2] granted, req[2] drops mid-burst while req[5]=1
//      -> no write in the drop cycle; gnt=8'h20 at the next edge.
//   6. Assert rst_n=0 mid-burst between edges
//      -> gnt, wr_load, busy go 0 immediately; after release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/ram8_write_arbiter.sv
// ============================================================================
// Module  : ram8_write_arbiter
// Brief   : Round-robin burst arbiter for the single write port of an 8-word bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram8_write_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         req,
  input  logic [23:0]        addr,
  input  logic [8*WIDTH-1:0] data,
  output logic [7:0]         gnt,
  output logic               wr_load,
  output logic [2:0]         wr_sel,
  output logic [WIDTH-1:0]   wr_data,
  output logic               busy
);

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_grant  = 1'b1;
  localparam logic [4:0] c_max_burst = 5'(MAX_BURST);

  logic [0:0]       r_state, w_state_nxt;
  logic [2:0]       r_ptr, w_ptr_nxt;
  logic [3:0]       r_beat, w_beat_nxt;
  logic [2:0]       r_owner, w_owner_nxt;
  logic [7:0]       r_gnt, w_gnt_nxt;
  logic             r_wr_load;
  logic [2:0]       r_wr_sel;
  logic [WIDTH-1:0] r_wr_data;
  logic             w_accept;
  logic [3:0]       w_scan;
  logic [2:0]       w_addr [8];
  logic [WIDTH-1:0] w_data [8];

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_unpack
    assign w_addr[gi] = addr[3*gi +: 3];
    assign w_data[gi] = data[WIDTH*gi +: WIDTH];
  end

  // Returns {found, index} of the first set bit scanning upward from start, mod 8.
  function automatic logic [3:0] f_scan(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    f_scan = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) f_scan = {1'b1, idx};
    end
  endfunction

  // The owner's gnt bit is always set in GRANT, so acceptance only needs its req.
  assign w_accept = (r_state == c_st_grant) && req[r_owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_ptr     <= 3'd0;
      r_beat    <= 4'd0;
      r_owner   <= 3'd0;
      r_gnt     <= 8'd0;
      r_wr_load <= 1'b0;
      r_wr_sel  <= 3'd0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_beat    <= w_beat_nxt;
      r_owner   <= w_owner_nxt;
      r_gnt     <= w_gnt_nxt;
      r_wr_load <= w_accept;
      if (w_accept) begin
        r_wr_sel  <= w_addr[r_owner];
        r_wr_data <= w_data[r_owner];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = r_gnt;
    w_scan      = 4'b0;
    case (r_state)
      c_st_idle: begin
        w_scan = f_scan(req, r_ptr);
        if (w_scan[3]) begin
          w_state_nxt = c_st_grant;
          w_owner_nxt = w_scan[2:0];
          w_gnt_nxt   = 8'b1 << w_scan[2:0];
          w_beat_nxt  = 4'd0;
        end
      end
      default: begin
        if (req[r_owner] && (({1'b0, r_beat} + 5'd1) < c_max_burst)) begin
          w_beat_nxt = r_beat + 4'd1;
        end else begin
          // Scanning from owner+1 leaves the current owner at lowest priority.
          w_ptr_nxt  = r_owner + 3'd1;
          w_scan     = f_scan(req, r_owner + 3'd1);
          w_beat_nxt = 4'd0;
          if (w_scan[3]) begin
            w_owner_nxt = w_scan[2:0];
            w_gnt_nxt   = 8'b1 << w_scan[2:0];
          end else begin
            w_gnt_nxt   = 8'd0;
            w_state_nxt = c_st_idle;
          end
        end
      end
    endcase
  end

  always_comb begin
    gnt     = r_gnt;
    wr_load = r_wr_load;
    wr_sel  = r_wr_sel;
    wr_data = r_wr_data;
    busy    = (r_state == c_st_grant);
  end

endmodule

`default_nettype wire

// File: tb/tb_ram8_write_arbiter.sv
// ============================================================================
// Module  : tb_ram8_write_arbiter
// Brief   : Table-driven, scoreboarded bench for ram8_write_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram8_write_arbiter;

  localparam int WIDTH     = 16;
  localparam int MAX_BURST = 4;

  typedef struct {
    logic [7:0] req;
    logic       acc;
    logic [2:0] who;
    logic [7:0] gnt;
    logic       load;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         req = 8'd0;
  logic [23:0]        addr;
  logic [8*WIDTH-1:0] data;
  logic [7:0]         gnt;
  logic               wr_load;
  logic [2:0]         wr_sel;
  logic [WIDTH-1:0]   wr_data;
  logic               busy;

  logic [2:0]       a_arr [8];
  logic [WIDTH-1:0] d_arr [8];
  vec_t tbl [$];
  wr_t  sb  [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ram8_write_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .data(data),
    .gnt(gnt), .wr_load(wr_load), .wr_sel(wr_sel), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    addr = '0;
    data = '0;
    for (int i = 0; i < 8; i++) begin
      addr[3*i +: 3]         = a_arr[i];
      data[WIDTH*i +: WIDTH] = d_arr[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_load) begin
      if (sb.size() == 0) begin
        check("unexpected write", 32'(wr_sel), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write sel", 32'(wr_sel), 32'(e.sel));
        check("write data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] r, input logic acc, input logic [2:0] who,
                     input logic [7:0] g, input logic ld, input logic bz);
    vec_t v;
    v.req = r; v.acc = acc; v.who = who; v.gnt = g; v.load = ld; v.busy = bz;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    wr_t w;
    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req;
      if (tbl[i].acc) begin
        w.sel  = a_arr[tbl[i].who];
        w.data = d_arr[tbl[i].who];
        sb.push_back(w);
      end
      tick();
      check($sformatf("%s[%0d] gnt", tag, i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("%s[%0d] wr_load", tag, i), 32'(wr_load), 32'(tbl[i].load));
      check($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(tbl[i].busy));
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    req   = 8'd0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = 3'(i + 5);
      d_arr[i] = 16'(16'hBEEF + 16'h0101 * i);
    end

    // Reset state
    do_reset();
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset wr_load", 32'(wr_load), 32'h0);
    check("reset wr_sel", 32'(wr_sel), 32'h0);
    check("reset wr_data", 32'(wr_data), 32'h0);
    check("reset busy", 32'(busy), 32'h0);

    // Single write from requester 0: gnt one cycle, strobe the next, then idle.
    add(8'h01, 0, 0, 8'h01, 0, 1);
    add(8'h01, 1, 0, 8'h01, 1, 1);
    add(8'h00, 0, 0, 8'h00, 0, 0);
    add(8'h00, 0, 0, 8'h00, 0, 0);
    run_table("t1");

    // All requesting: bursts of MAX_BURST rotating 0..7 then 0, no gaps.
    do_reset();
    add(8'hFF, 0, 0, 8'h01, 0, 1);
    for (int c = 0; c < 9 * MAX_BURST; c++) begin
      add(8'hFF, 1, 3'((c / MAX_BURST) % 8), 8'b1 << (((c + 1) / MAX_BURST) % 8), 1, 1);
    end
    add(8'h00, 0, 0, 8'h00, 0, 0);
    run_table("t2");

    // Park ptr at 6, then 6 and 0 compete; 0 follows via wrap; ptr ends at 1.
    do_reset();
    add(8'h20, 0, 0, 8'h20, 0, 1);
    add(8'h00, 0, 0, 8'h00, 0, 0);
    add(8'h41, 0, 0, 8'h40, 0, 1);
    add(8'h41, 1, 6, 8'h40, 1, 1);
    add(8'h41, 1, 6, 8'h40, 1, 1);
    add(8'h41, 1, 6, 8'h40, 1, 1);
    add(8'h41, 1, 6, 8'h01, 1, 1);
    add(8'h01, 1, 0, 8'h01, 1, 1);
    add(8'h00, 0, 0, 8'h00, 0, 0);
    add(8'h03, 0, 0, 8'h02, 0, 1);
    add(8'h00, 0, 0, 8'h00, 0, 0);
    run_table("t3");

    // Lone requester re-granted across burst boundaries without a bubble.
    do_reset();
    add(8'h08, 0, 0, 8'h08, 0, 1);
    for (int c = 0; c < 10; c++) add(8'h08, 1, 3, 8'h08, 1, 1);
    add(8'h00, 0, 0, 8'h00, 0, 0);
    run_table("t4");

    // Owner drops mid-burst: no write that cycle, grant moves to 5.
    do_reset();
    add(8'h24, 0, 0, 8'h04, 0, 1);
    add(8'h24, 1, 2, 8'h04, 1, 1);
    add(8'h20, 0, 0, 8'h20, 0, 1);
    add(8'h20, 1, 5, 8'h20, 1, 1);
    add(8'h00, 0, 0, 8'h00, 0, 0);
    run_table("t5");

    // Async reset mid-burst of requester 1; restart must grant 0 again.
    do_reset();
    add(8'hFF, 0, 0, 8'h01, 0, 1);
    add(8'hFF, 1, 0, 8'h01, 1, 1);
    add(8'hFF, 1, 0, 8'h01, 1, 1);
    add(8'hFF, 1, 0, 8'h01, 1, 1);
    add(8'hFF, 1, 0, 8'h02, 1, 1);
    add(8'hFF, 1, 1, 8'h02, 1, 1);
    run_table("t6");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6 async gnt", 32'(gnt), 32'h0);
    check("t6 async wr_load", 32'(wr_load), 32'h0);
    check("t6 async busy", 32'(busy), 32'h0);
    #1;
    rst_n = 1'b1;
    add(8'hFF, 0, 0, 8'h01, 0, 1);
    add(8'h00, 0, 0, 8'h00, 0, 0);
    run_table("t6r");

    tick();
    check("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
